// File: rtl/register_file.sv
// register_file: DEPTH x DATA_WIDTH general-purpose register bank.
// One synchronous write port, two independent combinational read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and
// out-of-range address guarding on both write and read.
module register_file #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter bit                    ZERO_REG0  = 1'b1,
    parameter bit                    BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_b
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic write_in_range;
    logic write_is_zero;
    logic write_hit;

    // Qualify the write: dropped on clear, out-of-range address or protected register 0
    always_comb begin
        write_in_range = 32'(write_addr) < DEPTH;
        write_is_zero  = ZERO_REG0 && (write_addr == '0);
        write_hit      = write_enable && !clear && write_in_range && !write_is_zero;
    end

    // Storage update: clear wins over write; address decode by comparison so DEPTH need not be 2**n
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= INIT;
            end
        end else if (write_hit) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(write_addr) == i) begin
                    regs[i] <= write_data;
                end
            end
        end
    end

    // Read port A: stored value, zero for out-of-range / hardwired R0, bypass on a live write hit
    always_comb begin
        read_data_a = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(read_addr_a) == i) begin
                read_data_a = regs[i];
            end
        end
        if (ZERO_REG0 && (read_addr_a == '0)) begin
            read_data_a = '0;
        end
        if (BYPASS && write_hit && (read_addr_a == write_addr)) begin
            read_data_a = write_data;
        end
    end

    // Read port B: identical rules, fully independent of port A
    always_comb begin
        read_data_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(read_addr_b) == i) begin
                read_data_b = regs[i];
            end
        end
        if (ZERO_REG0 && (read_addr_b == '0)) begin
            read_data_b = '0;
        end
        if (BYPASS && write_hit && (read_addr_b == write_addr)) begin
            read_data_b = write_data;
        end
    end

endmodule
